fp_cmp_arbiter: RTL

- Round-robin arbiter that shares one single-precision less-or-equal comparator (fpLess_equal, clocked on aclk) among NUM_REQ requesters.
- Each requester gets a valid/ready request channel and its own held response register.
- Tracks in-flight comparisons with a tag shift register sized to the comparator's fixed latency, and routes each result back to its issuer.

---
 rtl/fp_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_cmp_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared types, comparator result codes and ID width helper for fp_cmp_arbiter
package fp_arb_pkg;
    localparam int FP_W = 32;
    typedef logic [FP_W-1:0] fp_word_t;
    localparam fp_word_t CMP_TRUE = 32'h00000001;
    localparam fp_word_t CMP_FALSE = 32'h00000000;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant with a registered search pointer
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = id_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      grant_id_o
);
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, idx;
    logic          found;
    // First eligible index at or above the pointer, wrapping; pointer advances past the winner.
    always_comb begin
        found = 1'b0;
        grant_id_o = '0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && eligible_i[idx]) begin
                found = 1'b1;
                grant_id_o = idx;
            end
        end
        grant_o = found ? (NUM_REQ'(1) << grant_id_o) : '0;
        rr_ptr_d = (grant_id_o == IW'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;
    end
    // Pointer moves only when the grant is actually taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else if (accept_i) rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter: shares one fixed-latency fp <= comparator among NUM_REQ requesters; FP_ARB_PERF_CNT_EN adds issue_count
module fp_cmp_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CMP_LATENCY = 1
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_value1,
    input  logic [NUM_REQ*FP_W-1:0] req_value2,
    output logic [FP_W-1:0]         cmp_value1,
    output logic [FP_W-1:0]         cmp_value2,
    input  logic [FP_W-1:0]         cmp_result,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*FP_W-1:0] rsp_result,
    output logic                    busy
`ifdef FP_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             issue_count
`endif
);
    localparam int IW = id_width(NUM_REQ);
    // The operand register adds one edge ahead of the comparator's own latency.
    localparam int DEPTH = CMP_LATENCY + 1;

    logic [NUM_REQ-1:0][FP_W-1:0] v1, v2, rsp_result_q;
    logic [NUM_REQ-1:0]           pending, eligible, grant, rsp_valid_q;
    logic [IW-1:0]                grant_id;
    logic                         issue;
    logic [DEPTH-1:0]             tag_vld_q;
    logic [IW-1:0]                tag_id_q [DEPTH];
    fp_word_t                     cmp_value1_q, cmp_value2_q;

    assign v1 = req_value1;
    assign v2 = req_value2;

    // A requester is pending while its tag is in flight or its result is held.
    always_comb begin
        pending = rsp_valid_q;
        for (int s = 0; s < DEPTH; s++)
            if (tag_vld_q[s]) pending[tag_id_q[s]] = 1'b1;
    end

    assign eligible = req_valid & ~pending;
    assign req_ready = reset ? '0 : grant;
    assign issue = |(req_valid & req_ready);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk_i      (aclk),
        .rst_i      (reset),
        .eligible_i (eligible),
        .accept_i   (issue),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    // Tag pipe shifts every cycle; stage 0 records who issued this edge.
    always_ff @(posedge aclk) begin
        if (reset) begin
            tag_vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) tag_id_q[s] <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[DEPTH-2:0], issue};
            tag_id_q[0] <= grant_id;
            for (int s = 1; s < DEPTH; s++) tag_id_q[s] <= tag_id_q[s-1];
        end
    end

    // Operand registers feeding the comparator hold between issues.
    always_ff @(posedge aclk) begin
        if (reset) begin
            cmp_value1_q <= '0;
            cmp_value2_q <= '0;
        end else if (issue) begin
            cmp_value1_q <= v1[grant_id];
            cmp_value2_q <= v2[grant_id];
        end
    end

    // Consume clears a held flag; the emerging tag captures the comparator output.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_result_q <= {NUM_REQ{CMP_FALSE}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (rsp_valid_q[i] && rsp_ready[i]) rsp_valid_q[i] <= 1'b0;
            if (tag_vld_q[DEPTH-1]) begin
                rsp_valid_q[tag_id_q[DEPTH-1]] <= 1'b1;
                rsp_result_q[tag_id_q[DEPTH-1]] <= cmp_result;
            end
        end
    end

    assign cmp_value1 = cmp_value1_q;
    assign cmp_value2 = cmp_value2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy = |pending;

`ifdef FP_ARB_PERF_CNT_EN
    logic [31:0] issue_count_q;
    // Saturating handshake counter.
    always_ff @(posedge aclk) begin
        if (reset) issue_count_q <= '0;
        else if (issue && issue_count_q != '1) issue_count_q <= issue_count_q + 1'b1;
    end
    assign issue_count = issue_count_q;
`endif
endmodule
